// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
//   Single-beat req/ack data-memory bus between the MEM-stage controller
//   (master) and the data memory (slave).
//   bus_req    master -> slave   request, held until bus_ack
//   bus_we     master -> slave   1 = write, 0 = read; valid while bus_req
//   bus_addr   master -> slave   byte address; valid while bus_req
//   bus_wdata  master -> slave   write data; valid while bus_req
//   bus_ack    slave  -> master  acknowledge; only meaningful while bus_req
//   bus_rdata  slave  -> master  read data; valid in the bus_ack cycle
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Memory-stage bus controller. Turns a registered load/store strobe from
//   the MEM pipeline register into one single-beat req/ack bus transaction,
//   stalling the pipeline until it completes or times out.
//   clk       clock, rising edge
//   rst_n     asynchronous reset, active low
//   memrq_i   load request
//   memwq_i   store request
//   addr_i    byte address, valid with a strobe
//   wdata_i   store data, valid with memwq_i
//   stall_o   hold upstream pipeline (combinational)
//   done_o    one-cycle pulse: transaction completed
//   rdata_o   load result, valid from done until the next done
//   err_o     one-cycle pulse: illegal request or bus timeout
//   bus       data-memory bus, master side
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int TMO_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       memrq_i,
  input  logic                       memwq_i,
  input  logic [AW-1:0]              addr_i,
  input  logic [DW-1:0]              wdata_i,
  output logic                       stall_o,
  output logic                       done_o,
  output logic [DW-1:0]              rdata_o,
  output logic                       err_o,
  mem_access_ctrl_if.master          bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_t;

  // The counter holds the number of unacknowledged BUS cycles already spent
  // before the current one, so the 2**TMO_W-1'th waiting cycle is the one in
  // which the counter reads 2**TMO_W-2.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             strobe_one;
  logic             strobe_both;

  assign strobe_one  = memrq_i ^ memwq_i;
  assign strobe_both = memrq_i & memwq_i;

  // NOTE: every signal gets its hold/default value before the case statement,
  // so no path leaves a combinational output unassigned and no latch is built.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (strobe_one) begin
          state_d = S_BUS;
          tmo_d   = '0;
          req_d   = 1'b1;
          we_d    = memwq_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end else if (strobe_both) begin
          err_d = 1'b1;
        end
      end
      S_BUS: begin
        // An ack in the final waiting cycle still completes normally.
        if (bus.bus_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) rdata_d = bus.bus_rdata;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Stall covers the capture cycle and every BUS cycle; it is low in the
  // done/err cycle unless a fresh strobe is already waiting there.
  assign stall_o = ((state_q == S_IDLE) && strobe_one) || (state_q == S_BUS);

  assign done_o        = done_q;
  assign err_o         = err_q;
  assign rdata_o       = rdata_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl (TMO_W = 4, so a timeout takes 15
//   waiting cycles). Inputs change 1 ns after the rising edge; outputs are
//   observed 2 ns after the rising edge, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TMO_W = 4;

  logic          clk;
  logic          rst_n;
  logic          memrq;
  logic          memwq;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          stall;
  logic          done;
  logic [DW-1:0] rdata;
  logic          err;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl_if #(.AW(AW), .DW(DW)) bif ();

  mem_access_ctrl #(.AW(AW), .DW(DW), .TMO_W(TMO_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .memrq_i (memrq),
    .memwq_i (memwq),
    .addr_i  (addr),
    .wdata_i (wdata),
    .stall_o (stall),
    .done_o  (done),
    .rdata_o (rdata),
    .err_o   (err),
    .bus     (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the start of the next cycle's input window.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move from the input window to the observation point of the same cycle.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    memrq         = 1'b0;
    memwq         = 1'b0;
    addr          = '0;
    wdata         = '0;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;

    // ---------------- reset state ----------------
    step(); step();
    settle();
    check("rst_bus_req", bif.bus_req, 0);
    check("rst_bus_we", bif.bus_we, 0);
    check("rst_bus_addr", bif.bus_addr, 0);
    check("rst_bus_wdata", bif.bus_wdata, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_stall", stall, 0);
    rst_n = 1'b1;

    // ---------------- single read, 0-wait ack ----------------
    step();
    memrq = 1'b1; addr = 32'h0000_0100;
    settle();
    check("rd_n_stall", stall, 1);
    check("rd_n_req", bif.bus_req, 0);
    step();
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hDEAD_BEEF;
    settle();
    check("rd_n1_req", bif.bus_req, 1);
    check("rd_n1_we", bif.bus_we, 0);
    check("rd_n1_addr", bif.bus_addr, 32'h0000_0100);
    check("rd_n1_stall", stall, 1);
    check("rd_n1_done", done, 0);
    step();
    memrq = 1'b0; bif.bus_ack = 1'b0; bif.bus_rdata = '0;
    settle();
    check("rd_n2_done", done, 1);
    check("rd_n2_err", err, 0);
    check("rd_n2_rdata", rdata, 32'hDEAD_BEEF);
    check("rd_n2_req", bif.bus_req, 0);
    check("rd_n2_stall", stall, 0);
    step();
    settle();
    check("rd_n3_done", done, 0);

    // ---------------- single write, 3 waits ----------------
    step();
    memwq = 1'b1; addr = 32'h0000_0200; wdata = 32'h1234_5678;
    settle();
    check("wr_n_stall", stall, 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 4) begin
        bif.bus_ack = 1'b1; bif.bus_rdata = 32'hBAD0_BAD0;
      end
      settle();
      check($sformatf("wr_req_%0d", i), bif.bus_req, 1);
      check($sformatf("wr_we_%0d", i), bif.bus_we, 1);
      check($sformatf("wr_addr_%0d", i), bif.bus_addr, 32'h0000_0200);
      check($sformatf("wr_wdata_%0d", i), bif.bus_wdata, 32'h1234_5678);
      check($sformatf("wr_stall_%0d", i), stall, 1);
      check($sformatf("wr_done_%0d", i), done, 0);
    end
    step();
    memwq = 1'b0; bif.bus_ack = 1'b0; bif.bus_rdata = '0;
    settle();
    check("wr_n5_done", done, 1);
    check("wr_n5_rdata", rdata, 32'hDEAD_BEEF);
    check("wr_n5_req", bif.bus_req, 0);
    check("wr_n5_stall", stall, 0);

    // ---------------- timeout ----------------
    step();
    memrq = 1'b1; addr = 32'h0000_0300;
    settle();
    for (int i = 1; i <= 15; i++) begin
      step();
      settle();
      check($sformatf("tmo_req_%0d", i), bif.bus_req, 1);
      check($sformatf("tmo_flags_%0d", i), {done, err}, 0);
      check($sformatf("tmo_stall_%0d", i), stall, 1);
    end
    step();
    memrq = 1'b0;
    settle();
    check("tmo_req_drop", bif.bus_req, 0);
    check("tmo_err", err, 1);
    check("tmo_no_done", done, 0);
    check("tmo_stall", stall, 0);
    step();
    settle();
    check("tmo_err_pulse", err, 0);

    // ---------------- illegal request ----------------
    step();
    memrq = 1'b1; memwq = 1'b1; addr = 32'h0000_0700;
    settle();
    check("ill_n_stall", stall, 0);
    step();
    memrq = 1'b0; memwq = 1'b0;
    settle();
    check("ill_n1_err", err, 1);
    check("ill_n1_done", done, 0);
    check("ill_n1_req", bif.bus_req, 0);
    check("ill_n1_stall", stall, 0);
    step();
    settle();
    check("ill_n2_err", err, 0);
    check("ill_n2_req", bif.bus_req, 0);

    // ---------------- back-to-back read then write ----------------
    step();
    memrq = 1'b1; addr = 32'h0000_0400;
    settle();
    check("b2b_n_stall", stall, 1);
    step();
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hCAFE_F00D;
    settle();
    check("b2b_n1_stall", stall, 1);
    step();
    memrq = 1'b0; bif.bus_ack = 1'b0; bif.bus_rdata = '0;
    settle();
    check("b2b_n2_done", done, 1);
    check("b2b_n2_rdata", rdata, 32'hCAFE_F00D);
    check("b2b_n2_stall", stall, 0);
    step();
    memwq = 1'b1; addr = 32'h0000_0404; wdata = 32'h55AA_55AA;
    settle();
    check("b2b_n3_done", done, 0);
    check("b2b_n3_stall", stall, 1);
    step();
    bif.bus_ack = 1'b1;
    settle();
    check("b2b_n4_we", bif.bus_we, 1);
    check("b2b_n4_addr", bif.bus_addr, 32'h0000_0404);
    check("b2b_n4_wdata", bif.bus_wdata, 32'h55AA_55AA);
    check("b2b_n4_done", done, 0);
    check("b2b_n4_stall", stall, 1);
    step();
    memwq = 1'b0; bif.bus_ack = 1'b0;
    settle();
    check("b2b_n5_done", done, 1);
    check("b2b_n5_rdata", rdata, 32'hCAFE_F00D);
    check("b2b_n5_stall", stall, 0);

    // ---------------- reset in the middle of BUS ----------------
    step();
    memrq = 1'b1; addr = 32'h0000_0500;
    settle();
    step();
    memrq = 1'b0;
    settle();
    check("mrst_req_before", bif.bus_req, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_req_drop", bif.bus_req, 0);
    check("mrst_flags", {done, err}, 0);
    check("mrst_rdata", rdata, 0);
    check("mrst_stall", stall, 0);
    step();
    settle();
    check("mrst_flags_hold", {done, err}, 0);
    rst_n = 1'b1;
    step();
    settle();
    check("mrst_idle_req", bif.bus_req, 0);
    check("mrst_idle_stall", stall, 0);
    // FSM must accept a fresh read immediately after release.
    step();
    memrq = 1'b1; addr = 32'h0000_0600;
    settle();
    step();
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0BAD_CAFE;
    settle();
    check("mrst_rd_req", bif.bus_req, 1);
    check("mrst_rd_addr", bif.bus_addr, 32'h0000_0600);
    step();
    memrq = 1'b0; bif.bus_ack = 1'b0;
    settle();
    check("mrst_rd_done", done, 1);
    check("mrst_rd_rdata", rdata, 32'h0BAD_CAFE);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
